// File: rtl/axi2mem_pkg.sv
// Shared types for the axi2mem bridge: AXI burst encodings, beat geometry,
// read-splitter state and the captured AR command.
package axi2mem_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_ID_W   = 6;
  localparam int unsigned BEAT_BYTES = 8;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic {
    RD_IDLE,
    RD_BURST
  } rd_state_e;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [1:0]            size;
    burst_e                burst;
    logic [AXI_ID_W-1:0]   id;
  } ar_cmd_t;

  // The beat is 64 bits wide, so anything wider than 8 bytes is treated as 8.
  function automatic logic [1:0] clamp_size(input logic [2:0] size);
    return (size > 3'd3) ? 2'd3 : size[1:0];
  endfunction

endpackage

// File: rtl/axi2mem_rd_addr_gen.sv
// Combinational beat calculator: per-lane word addresses, 8-byte lane mask and
// the address of the following beat for FIXED / INCR / WRAP bursts.
module axi2mem_rd_addr_gen
  import axi2mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = AXI_ADDR_W
) (
  input  logic [ADDR_WIDTH-1:0]      addr,
  input  logic [7:0]                 len,
  input  logic [1:0]                 size,
  input  burst_e                     burst,
  output logic [ADDR_WIDTH-1:0]      next_addr,
  output logic [1:0][ADDR_WIDTH-1:0] lane_addr,
  output logic [BEAT_BYTES-1:0]      be
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] align_mask;
  logic [ADDR_WIDTH-1:0] aligned;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] beat_base;
  logic                  wrap_ok;
  logic [BEAT_BYTES-1:0] size_bytes;
  logic [2:0]            lane_off_mask;

  assign step       = ADDR_WIDTH'(1) << size;
  assign align_mask = step - ADDR_WIDTH'(1);
  assign aligned    = addr & ~align_mask;
  assign wrap_mask  = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
  assign wrap_ok    = len inside {8'd1, 8'd3, 8'd7, 8'd15};

  always_comb begin
    // NOTE: default assignment first so no branch can leave next_addr unassigned and infer a latch.
    next_addr = aligned + step;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP: begin
        // Illegal wrap lengths fall through to the INCR default above.
        if (wrap_ok) next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
      end
      default: ;
    endcase
  end

  assign beat_base    = addr & ~ADDR_WIDTH'(BEAT_BYTES - 1);
  assign lane_addr[0] = beat_base;
  assign lane_addr[1] = beat_base + ADDR_WIDTH'(BEAT_BYTES / 2);

  always_comb begin
    size_bytes    = 8'hFF;
    lane_off_mask = 3'b000;
    case (size)
      2'd0: begin size_bytes = 8'h01; lane_off_mask = 3'b111; end
      2'd1: begin size_bytes = 8'h03; lane_off_mask = 3'b110; end
      2'd2: begin size_bytes = 8'h0F; lane_off_mask = 3'b100; end
      default: ;
    endcase
  end

  // Unaligned start addresses are aligned down to the transfer size here.
  assign be = size_bytes << (addr[2:0] & lane_off_mask);

endmodule

// File: rtl/axi2mem_rd_burst_split.sv
// AXI AR burst splitter: turns one 64-bit read burst into lock-stepped pairs of
// 32-bit lane commands, one pair per beat, for the TCDM read command queues.
module axi2mem_rd_burst_split
  import axi2mem_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 6
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           ar_valid_i,
  output logic                           ar_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0]      ar_addr_i,
  input  logic [7:0]                     ar_len_i,
  input  logic [2:0]                     ar_size_i,
  input  logic [1:0]                     ar_burst_i,
  input  logic [AXI_ID_WIDTH-1:0]        ar_id_i,
  output logic [1:0]                     trans_rd_req_o,
  input  logic [1:0]                     trans_rd_gnt_i,
  output logic [1:0][AXI_ADDR_WIDTH-1:0] trans_rd_add_o,
  output logic [1:0][3:0]                trans_rd_be_o,
  output logic [1:0][AXI_ID_WIDTH-1:0]   trans_rd_id_o,
  output logic [1:0]                     trans_rd_last_o
);

  rd_state_e                  state_q;
  ar_cmd_t                    cmd_q;
  logic [7:0]                 cnt_q;
  logic                       fire;
  logic                       last;
  logic                       ar_hs;
  logic [AXI_ADDR_W-1:0]      next_addr;
  logic [1:0][AXI_ADDR_W-1:0] lane_addr;
  logic [BEAT_BYTES-1:0]      be;

  axi2mem_rd_addr_gen #(
    .ADDR_WIDTH (AXI_ADDR_W)
  ) u_addr_gen (
    .addr      (cmd_q.addr),
    .len       (cmd_q.len),
    .size      (cmd_q.size),
    .burst     (cmd_q.burst),
    .next_addr (next_addr),
    .lane_addr (lane_addr),
    .be        (be)
  );

  // Both lanes must be granted together; downstream reads ID/last from lane 0 only.
  assign last       = (cnt_q == 8'd0);
  assign fire       = (state_q == RD_BURST) & (&trans_rd_gnt_i);
  assign ar_ready_o = (state_q == RD_IDLE) | (fire & last);
  assign ar_hs      = ar_valid_i & ar_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RD_IDLE;
      cmd_q   <= '0;
      cnt_q   <= '0;
    end else if (ar_hs) begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      state_q     <= RD_BURST;
      cmd_q.addr  <= AXI_ADDR_W'(ar_addr_i);
      cmd_q.len   <= ar_len_i;
      cmd_q.size  <= clamp_size(ar_size_i);
      cmd_q.burst <= burst_e'(ar_burst_i);
      cmd_q.id    <= AXI_ID_W'(ar_id_i);
      cnt_q       <= ar_len_i;
    end else if (fire) begin
      if (last) begin
        state_q <= RD_IDLE;
      end else begin
        cmd_q.addr <= next_addr;
        cnt_q      <= cnt_q - 8'd1;
      end
    end
  end

  assign trans_rd_req_o    = {2{fire}};
  assign trans_rd_add_o[0] = AXI_ADDR_WIDTH'(lane_addr[0]);
  assign trans_rd_add_o[1] = AXI_ADDR_WIDTH'(lane_addr[1]);
  assign trans_rd_be_o[0]  = be[3:0];
  assign trans_rd_be_o[1]  = be[7:4];
  assign trans_rd_id_o[0]  = AXI_ID_WIDTH'(cmd_q.id);
  assign trans_rd_id_o[1]  = AXI_ID_WIDTH'(cmd_q.id);
  assign trans_rd_last_o   = {2{last}};

endmodule
